// File: rtl/ccu_cmd_arbiter.sv
// Two-source command arbiter in front of the CCU: grants one requester per
// packet, forwards it whole with one cycle of latency and paces against ccu_busy.
module ccu_cmd_arbiter #(
  parameter logic [7:0]  OP_POINT = 8'd80,
  parameter logic [7:0]  OP_LINE  = 8'd76,
  parameter logic [7:0]  IDLE_CMD = 8'd0,
  parameter int unsigned GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        ccu_busy,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [1:0]  grant,
  output logic        bad_op,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    FWD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);

  state_t     state_r;
  logic [2:0] remaining_r;
  logic [3:0] wait_cnt_r;
  logic       last_r;
  logic       xfer_s;
  logic [7:0] byte_s;
  logic       win_s;

  assign xfer_s = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign byte_s = grant[1] ? req1_data : req0_data;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    win_s = 1'b0;
    if (req0_valid && req1_valid) begin
      win_s = ~last_r;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Packet state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ARB;
      cmd         <= IDLE_CMD;
      cmd_valid   <= 1'b0;
      grant       <= 2'b00;
      bad_op      <= 1'b0;
      pkt_count   <= 16'd0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      remaining_r <= 3'd0;
      wait_cnt_r  <= 4'd0;
      last_r      <= 1'b1;
    end else begin
      cmd       <= IDLE_CMD;
      cmd_valid <= 1'b0;
      bad_op    <= 1'b0;
      case (state_r)
        ARB: begin
          if (req0_valid || req1_valid) begin
            grant       <= win_s ? 2'b10 : 2'b01;
            req0_ready  <= ~win_s;
            req1_ready  <= win_s;
            remaining_r <= 3'd0;
            state_r     <= FWD;
          end else begin
            grant <= 2'b00;
          end
        end
        FWD: begin
          // remaining_r == 0 inside FWD means the next byte is the opcode.
          if (xfer_s) begin
            if (remaining_r == 3'd0) begin
              if (byte_s == OP_POINT || byte_s == OP_LINE) begin
                cmd         <= byte_s;
                cmd_valid   <= 1'b1;
                remaining_r <= (byte_s == OP_POINT) ? 3'd3 : 3'd5;
              end else begin
                bad_op     <= 1'b1;
                last_r     <= grant[1];
                grant      <= 2'b00;
                req0_ready <= 1'b0;
                req1_ready <= 1'b0;
                state_r    <= ARB;
              end
            end else begin
              cmd         <= byte_s;
              cmd_valid   <= 1'b1;
              remaining_r <= remaining_r - 3'd1;
              if (remaining_r == 3'd1) begin
                pkt_count  <= pkt_count + 16'd1;
                last_r     <= grant[1];
                req0_ready <= 1'b0;
                req1_ready <= 1'b0;
                wait_cnt_r <= 4'd0;
                state_r    <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt_r >= GUARD_LAST && !ccu_busy) begin
            grant   <= 2'b00;
            state_r <= ARB;
          end else if (wait_cnt_r < 4'd15) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        default: begin
          grant      <= 2'b00;
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          state_r    <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_cmd_arbiter.sv
// Scoreboard bench for ccu_cmd_arbiter: packet-level reference model feeds an
// expectation queue that a free-running monitor drains against the DUT outputs.
module tb_ccu_cmd_arbiter;
  localparam logic [7:0] OP_POINT = 8'd80;
  localparam logic [7:0] OP_LINE  = 8'd76;
  localparam logic [7:0] IDLE_CMD = 8'd0;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] req0_data, req1_data;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic ccu_busy;
  logic [7:0] cmd;
  logic cmd_valid, bad_op;
  logic [1:0] grant;
  logic [15:0] pkt_count;

  ccu_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .ccu_busy(ccu_busy), .cmd(cmd), .cmd_valid(cmd_valid),
    .grant(grant), .bad_op(bad_op), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bad;
    logic [7:0]  data;
    int          stamp;
    logic [15:0] cnt;
    int          owner;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  src0[$];
  logic [7:0]  src1[$];
  int          served_q[$];
  int          pos[2];
  int          plen[2];
  logic [15:0] exp_cnt;
  bit          pace_on;
  int          pace_n, pace_owner;
  int          cyc = 0;
  int          last_op_cyc, fall_cyc;
  int          stall_pct;
  bit          busy_rand;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: packet framing from the opcode, counts and pacing windows.
  task automatic model_accept(input int r, input logic [7:0] b);
    exp_t e;
    e.stamp = cyc; e.owner = r; e.data = b; e.bad = 1'b0;
    if (pos[r] == 0) begin
      chk("no_interleave", pos[1-r], 0);
      chk("op_while_paced", {31'd0, pace_on}, 0);
      last_op_cyc = cyc;
      if (b == OP_POINT) plen[r] = 4;
      else if (b == OP_LINE) plen[r] = 6;
      else e.bad = 1'b1;
    end
    if (!e.bad) begin
      pos[r]++;
      if (pos[r] == plen[r]) begin
        pos[r] = 0;
        exp_cnt++;
        served_q.push_back(r);
        pace_on = 1'b1; pace_n = cyc; pace_owner = r;
      end
    end
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic model_flush();
    sb_q.delete(); src0.delete(); src1.delete(); served_q.delete();
    pos[0] = 0; pos[1] = 0; pace_on = 1'b0; exp_cnt = 16'd0;
  endtask

  task automatic drive();
    if (src0.size() > 0 && $urandom_range(99) >= stall_pct) begin
      req0_valid = 1'b1; req0_data = src0[0];
    end else begin
      req0_valid = 1'b0; req0_data = 8'($urandom);
    end
    if (src1.size() > 0 && $urandom_range(99) >= stall_pct) begin
      req1_valid = 1'b1; req1_data = src1[0];
    end else begin
      req1_valid = 1'b0; req1_data = 8'($urandom);
    end
    if (busy_rand && $urandom_range(3) == 0) ccu_busy = ~ccu_busy;
  endtask

  task automatic step();
    bit hs0, hs1;
    @(negedge clk);
    hs0 = !rst && req0_valid && req0_ready;
    hs1 = !rst && req1_valid && req1_ready;
    if (hs0) model_accept(0, req0_data);
    if (hs1) model_accept(1, req1_data);
    @(posedge clk); #1;
    if (hs0) void'(src0.pop_front());
    if (hs1) void'(src1.pop_front());
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || sb_q.size() > 0 || pace_on) && n < budget) begin
      step(); n++;
    end
    chk("drain_in_budget", {31'd0, n < budget}, 1);
    step(); step();
  endtask

  task automatic load(input int r, input int n, input logic [7:0] b0, b1, b2, b3, b4, b5);
    logic [7:0] p [6];
    p = '{b0, b1, b2, b3, b4, b5};
    for (int i = 0; i < n; i++) begin
      if (r == 0) src0.push_back(p[i]); else src1.push_back(p[i]);
    end
  endtask

  task automatic add_random_pkt(input int r);
    int k = $urandom_range(9);
    logic [7:0] b = 8'($urandom);
    if (k == 0) begin
      if (b == OP_POINT || b == OP_LINE) b = b + 8'd1;
      load(r, 1, b, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    end else if (k <= 5) begin
      load(r, 4, OP_POINT, 8'($urandom), 8'($urandom), 8'($urandom), 8'd0, 8'd0);
    end else begin
      load(r, 6, OP_LINE, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"}, {24'd0, cmd}, {24'd0, IDLE_CMD});
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 0);
    chk({tag, "_grant"}, {30'd0, grant}, 0);
    chk({tag, "_bad_op"}, {31'd0, bad_op}, 0);
    chk({tag, "_pkt_count"}, {16'd0, pkt_count}, 0);
    chk({tag, "_readys"}, {30'd0, req0_ready, req1_ready}, 0);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    model_flush();
    drive();
    #1 check_reset_outputs(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: protocol rules every cycle, and scoreboard drain on each presented output.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 0);
      if (req0_ready) chk("ready0_owner", {30'd0, grant}, 1);
      if (req1_ready) chk("ready1_owner", {30'd0, grant}, 2);
      if (!cmd_valid) chk("cmd_idle", {24'd0, cmd}, {24'd0, IDLE_CMD});
      if (pace_on && cyc > pace_n) begin
        chk("wait_readys", {30'd0, req0_ready, req1_ready}, 0);
        chk("wait_grant", {30'd0, grant}, (pace_owner == 1) ? 32'd2 : 32'd1);
        if (cyc >= pace_n + GUARD && !ccu_busy) pace_on = 1'b0;
      end
      while (sb_q.size() > 0 && sb_q[0].stamp + 1 < cyc) begin
        chk("missing_output", cyc, sb_q[0].stamp + 1);
        void'(sb_q.pop_front());
      end
      if (cmd_valid || bad_op) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {30'd0, cmd_valid, bad_op}, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("latency", cyc, mon_e.stamp + 1);
          chk("pkt_count", {16'd0, pkt_count}, {16'd0, mon_e.cnt});
          if (mon_e.bad) begin
            chk("bad_op_pulse", {31'd0, bad_op}, 1);
            chk("bad_no_cmd", {31'd0, cmd_valid}, 0);
            chk("bad_grant_clear", {30'd0, grant}, 0);
          end else begin
            chk("cmd", {24'd0, cmd}, {24'd0, mon_e.data});
            chk("bad_op_quiet", {31'd0, bad_op}, 0);
            chk("cmd_grant", {30'd0, grant}, (mon_e.owner == 1) ? 32'd2 : 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] cnt_before;
    rst = 1'b1; ccu_busy = 1'b0; stall_pct = 0; busy_rand = 1'b0;
    model_flush();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single Point on req0, back to back.
    load(0, 4, 8'd80, 8'd10, 8'd20, 8'd7, 8'd0, 8'd0);
    run_until_idle(100);
    chk("t1_pkt_count", {16'd0, pkt_count}, 1);
    chk("t1_owner", served_q.size() > 0 ? served_q[0] : 99, 0);

    // Both requesters valid from the first cycle after reset: strict alternation.
    do_reset("t2_reset");
    load(0, 4, 8'd80, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0);
    load(0, 4, 8'd80, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0);
    load(0, 4, 8'd80, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0);
    load(1, 6, 8'd76, 8'd1, 8'd2, 8'd9, 8'd5, 8'd3);
    load(1, 4, 8'd80, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0);
    load(1, 4, 8'd80, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0);
    run_until_idle(300);
    chk("t2_served", served_q.size(), 6);
    for (int i = 0; i < served_q.size(); i++) chk("t2_rr_order", served_q[i], i % 2);
    chk("t2_pkt_count", {16'd0, pkt_count}, 6);

    // Busy pacing: Line on req0, busy held 40 cycles, then req1's Point.
    served_q.delete();
    ccu_busy = 1'b1;
    load(0, 6, 8'd76, 8'd8, 8'd9, 8'd30, 8'd31, 8'd2);
    load(1, 4, 8'd80, 8'd6, 8'd6, 8'd6, 8'd0, 8'd0);
    n = 0;
    while (served_q.size() == 0 && n < 100) begin step(); n++; end
    chk("t3_line_done", {31'd0, n < 100}, 1);
    chk("t3_first_owner", served_q.size() > 0 ? served_q[0] : 99, 0);
    repeat (40) step();
    ccu_busy = 1'b0;
    fall_cyc = cyc;
    run_until_idle(100);
    chk("t3_op_after_busy", last_op_cyc, fall_cyc + 2);

    // Unknown opcode from req1, then a Point from req0.
    served_q.delete();
    cnt_before = exp_cnt;
    load(1, 1, 8'h55, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_until_idle(50);
    chk("t4_count_after_bad", {16'd0, pkt_count}, {16'd0, cnt_before});
    load(0, 4, 8'd80, 8'd11, 8'd12, 8'd13, 8'd0, 8'd0);
    run_until_idle(100);
    chk("t4_owner", served_q.size() > 0 ? served_q[0] : 99, 0);
    chk("t4_pkt_count", {16'd0, pkt_count}, {16'd0, cnt_before + 16'd1});

    // Mid-packet stall, reset during the stall, then a full resend.
    load(0, 2, 8'd76, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
    n = 0;
    while (src0.size() > 0 && n < 50) begin step(); n++; end
    repeat (5) begin
      step();
      chk("t5_grant_hold", {30'd0, grant}, 1);
      chk("t5_ready_hold", {31'd0, req0_ready}, 1);
    end
    do_reset("t5_reset");
    load(0, 6, 8'd76, 8'd4, 8'd1, 8'd2, 8'd3, 8'd9);
    run_until_idle(100);
    chk("t5_pkt_count", {16'd0, pkt_count}, 1);

    // Counter wrap from FFFF.
    force dut.pkt_count = 16'hFFFF;
    step();
    release dut.pkt_count;
    chk("t6_preload", {16'd0, pkt_count}, 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    load(0, 4, 8'd80, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0);
    run_until_idle(100);
    chk("t6_wrap", {16'd0, pkt_count}, 0);

    // Random traffic with stalls, bad opcodes and a wandering ccu_busy.
    do_reset("t7_reset");
    stall_pct = 25;
    busy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      add_random_pkt(0);
      add_random_pkt(1);
    end
    run_until_idle(20000);
    busy_rand = 1'b0;
    ccu_busy = 1'b0;
    run_until_idle(100);
    chk("t7_pkt_count", {16'd0, pkt_count}, {16'd0, exp_cnt});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
